// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants, op codes and state encodings for the
// MEM pipeline stage, plus small decode helpers for memory op codes.
package mem_stage_pkg;

    localparam logic        ENABLE       = 1'b1;
    localparam logic        DISABLE      = 1'b0;
    localparam logic [31:0] ZERO_32      = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
    localparam int          MEM_OP_BUS   = 4;

    typedef enum logic [MEM_OP_BUS-1:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LH   = 4'd2,
        MEM_OP_LW   = 4'd3,
        MEM_OP_LBU  = 4'd4,
        MEM_OP_LHU  = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } stage_state_e;

    function automatic logic op_is_load(input logic [MEM_OP_BUS-1:0] op);
        return (op == MEM_OP_LB)  || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
               (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [MEM_OP_BUS-1:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    // Index of the final byte of the access (byte count minus one).
    function automatic logic [1:0] op_last_idx(input logic [MEM_OP_BUS-1:0] op);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2'd1;
            MEM_OP_LW, MEM_OP_SW:             return 2'd3;
            default:                          return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [MEM_OP_BUS-1:0] op,
                                                input logic [31:0] data);
        case (op)
            MEM_OP_LB:  return {{24{data[7]}}, data[7:0]};
            MEM_OP_LBU: return {24'h000000, data[7:0]};
            MEM_OP_LH:  return {{16{data[15]}}, data[15:0]};
            MEM_OP_LHU: return {16'h0000, data[15:0]};
            default:    return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the RV32I pipeline. Non-memory ops pass straight
// through; loads/stores are serialised into byte requests on a req/ack port,
// little-endian, holding the upstream pipeline via stall_req.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   ex_wd/ex_wreg/ex_wdata   writeback fields from EX/MEM
//   ex_mem_op/addr/sdata     memory op, effective address, store data
//   mem_wd/wreg/wdata        writeback fields to mem_wb
//   stall_req                hold IF..EX/MEM while an access is in flight
//   mem_req/we/addr/wbyte    byte request to memory
//   mem_rbyte/mem_ack        read byte and one-cycle completion pulse
//
// state  | meaning
// IDLE   | pass-through; a memory op raises stall and starts an access
// ACCESS | one byte request per ack, idx walks 0..n-1
// DONE   | one cycle presenting the extended load result / store writeback
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [31:0]       ex_mem_sdata,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wbyte,
    input  logic [7:0]        mem_rbyte,
    input  logic              mem_ack
);

    stage_state_e state_q;
    logic [1:0]   idx_q;
    logic [31:0]  rbuf_q;

    logic is_load;
    logic is_store;
    logic is_mem;

    assign is_load  = op_is_load(ex_mem_op);
    assign is_store = op_is_store(ex_mem_op);
    // Unknown op codes decode as neither load nor store, i.e. as NONE.
    assign is_mem   = is_load | is_store;

    always_ff @(posedge clk) begin
        if (rst == ENABLE) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            rbuf_q  <= ZERO_32;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem) begin
                        state_q <= ST_ACCESS;
                        idx_q   <= 2'd0;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (is_load) begin
                            rbuf_q[{idx_q, 3'b000} +: 8] <= mem_rbyte;
                        end
                        if (idx_q == op_last_idx(ex_mem_op)) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    idx_q   <= 2'd0;
                    rbuf_q  <= ZERO_32;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= 2'd0;
                    rbuf_q  <= ZERO_32;
                end
            endcase
        end
    end

    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        stall_req = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        // Address wraps naturally at 2^ADDR_W; misaligned accesses are allowed.
        mem_addr  = ex_mem_addr + {{(ADDR_W-2){1'b0}}, idx_q};
        mem_wbyte = ex_mem_sdata[{idx_q, 3'b000} +: 8];

        if (rst == ENABLE) begin
            mem_wd    = NOP_REG_ADDR;
            mem_wreg  = DISABLE;
            mem_wdata = ZERO_32;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem) begin
                        stall_req = 1'b1;
                        mem_wreg  = DISABLE;
                        mem_wd    = NOP_REG_ADDR;
                    end
                end
                ST_ACCESS: begin
                    mem_req   = 1'b1;
                    mem_we    = is_store;
                    stall_req = 1'b1;
                    mem_wreg  = DISABLE;
                    mem_wd    = NOP_REG_ADDR;
                end
                ST_DONE: begin
                    if (is_load) begin
                        mem_wdata = load_extend(ex_mem_op, rbuf_q);
                    end
                end
                default: begin
                    mem_wreg = DISABLE;
                    mem_wd   = NOP_REG_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_sdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wbyte;
    logic [7:0]  mem_rbyte;
    logic        mem_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stall_req(stall_req), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wbyte(mem_wbyte),
        .mem_rbyte(mem_rbyte), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;     // bytes returned by memory, little-endian
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata_in;
        logic [31:0] exp_wdata;
        int          delay;     // idle cycles before each ack
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int byte_count(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
            MEM_OP_LW, MEM_OP_SW:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic logic is_st(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    // Called just after a posedge; leaves the bench just after a posedge with op NONE.
    task automatic run_access(input vec_t v);
        int n;
        int stalls;
        logic [31:0] exp_addr;
        n = byte_count(v.op);
        stalls = 0;
        ex_mem_op = v.op; ex_mem_addr = v.addr; ex_mem_sdata = v.sdata;
        ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata_in;
        @(negedge clk);
        check("idle_stall", {31'b0, stall_req}, 32'd1);
        check("idle_bubble_wreg", {31'b0, mem_wreg}, 32'd0);
        check("idle_bubble_wd", {27'b0, mem_wd}, 32'd0);
        check("idle_no_req", {31'b0, mem_req}, 32'd0);
        if (stall_req) stalls++;
        @(posedge clk); #1;
        for (int b = 0; b < n; b++) begin
            exp_addr = v.addr + b;
            for (int w = 0; w <= v.delay; w++) begin
                @(negedge clk);
                check("acc_req", {31'b0, mem_req}, 32'd1);
                check("acc_addr", mem_addr, exp_addr);
                check("acc_we", {31'b0, mem_we}, {31'b0, is_st(v.op)});
                check("acc_bubble_wreg", {31'b0, mem_wreg}, 32'd0);
                if (is_st(v.op)) check("acc_wbyte", {24'b0, mem_wbyte}, {24'b0, v.sdata[8*b +: 8]});
                if (stall_req) stalls++;
                if (w == v.delay) begin
                    mem_ack = 1'b1;
                    mem_rbyte = v.rdata[8*b +: 8];
                end else begin
                    mem_rbyte = 8'h5A;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        @(negedge clk);
        check("done_stall", {31'b0, stall_req}, 32'd0);
        check("done_req", {31'b0, mem_req}, 32'd0);
        check("done_wdata", mem_wdata, v.exp_wdata);
        check("done_wreg", {31'b0, mem_wreg}, {31'b0, v.wreg});
        check("done_wd", {27'b0, mem_wd}, {27'b0, v.wd});
        check("stall_cycles", stalls, 1 + n * (v.delay + 1));
        @(posedge clk); #1;
        ex_mem_op = MEM_OP_NONE;
        @(negedge clk);
        check("back_idle_stall", {31'b0, stall_req}, 32'd0);
        check("back_idle_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        mem_ack = 1'b0; mem_rbyte = 8'h00;
        ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h100; ex_mem_sdata = 32'h0;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
        rst = 1'b1;

        //           op          addr          sdata          rdata          wd     wreg  wdata_in       exp_wdata      delay
        vecs.push_back('{MEM_OP_LW,  32'h100,      32'h0,         32'h12345678, 5'd1,  1'b1, 32'h0,         32'h12345678, 0});
        vecs.push_back('{MEM_OP_LB,  32'h200,      32'h0,         32'h00000080, 5'd2,  1'b1, 32'h0,         32'hFFFFFF80, 0});
        vecs.push_back('{MEM_OP_LBU, 32'h200,      32'h0,         32'h00000080, 5'd3,  1'b1, 32'h0,         32'h00000080, 0});
        vecs.push_back('{MEM_OP_LH,  32'h300,      32'h0,         32'h00008000, 5'd4,  1'b1, 32'h0,         32'hFFFF8000, 0});
        vecs.push_back('{MEM_OP_LHU, 32'h300,      32'h0,         32'h00008000, 5'd5,  1'b1, 32'h0,         32'h00008000, 0});
        vecs.push_back('{MEM_OP_LB,  32'h201,      32'h0,         32'h0000007F, 5'd6,  1'b1, 32'h0,         32'h0000007F, 0});
        vecs.push_back('{MEM_OP_SH,  32'hFFFFFFFF, 32'hAABBCCDD,  32'h0,        5'd0,  1'b0, 32'hDEAD0000, 32'hDEAD0000, 0});
        vecs.push_back('{MEM_OP_SB,  32'h10,       32'h11223344,  32'h0,        5'd0,  1'b0, 32'h00000010, 32'h00000010, 0});
        vecs.push_back('{MEM_OP_SW,  32'h20,       32'hCAFEBABE,  32'h0,        5'd0,  1'b0, 32'h00000020, 32'h00000020, 1});
        vecs.push_back('{MEM_OP_LW,  32'h500,      32'h0,         32'h89ABCDEF, 5'd10, 1'b1, 32'h0,         32'h89ABCDEF, 3});

        // Reset holds outputs in the bubble state regardless of inputs.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_stall", {31'b0, stall_req}, 32'd0);
        check("rst_wreg", {31'b0, mem_wreg}, 32'd0);
        check("rst_wd", {27'b0, mem_wd}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_mem_op = MEM_OP_NONE;

        // Same-cycle pass-through for NONE and for an unknown op code.
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
        #1;
        check("pass_wd", {27'b0, mem_wd}, 32'd5);
        check("pass_wreg", {31'b0, mem_wreg}, 32'd1);
        check("pass_wdata", mem_wdata, 32'h1234);
        check("pass_stall", {31'b0, stall_req}, 32'd0);
        check("pass_req", {31'b0, mem_req}, 32'd0);
        ex_mem_op = 4'hF; ex_wd = 5'd17; ex_wdata = 32'hA5A5_0001;
        #1;
        check("unk_wd", {27'b0, mem_wd}, 32'd17);
        check("unk_wdata", mem_wdata, 32'hA5A5_0001);
        check("unk_stall", {31'b0, stall_req}, 32'd0);
        @(negedge clk);
        check("unk_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        ex_mem_op = MEM_OP_NONE;

        for (int i = 0; i < vecs.size(); i++) begin
            run_access(vecs[i]);
        end

        // Stray ack while idle must not disturb anything.
        mem_ack = 1'b1; mem_rbyte = 8'hEE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("stray_stall", {31'b0, stall_req}, 32'd0);
        check("stray_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        run_access('{MEM_OP_LB, 32'h600, 32'h0, 32'h000000C3, 5'd12, 1'b1, 32'h0, 32'hFFFFFFC3, 0});

        // Reset during byte 2 of a word load abandons the transfer.
        ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h400; ex_wd = 5'd8; ex_wreg = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_rbyte = 8'h11;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        @(negedge clk);
        check("mid_addr_byte2", mem_addr, 32'h402);
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, mem_req}, 32'd0);
        check("mid_rst_stall", {31'b0, stall_req}, 32'd0);
        check("mid_rst_wreg", {31'b0, mem_wreg}, 32'd0);
        check("mid_rst_wd", {27'b0, mem_wd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_mem_op = MEM_OP_NONE; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'h55;
        @(negedge clk);
        check("post_rst_req", {31'b0, mem_req}, 32'd0);
        check("post_rst_stall", {31'b0, stall_req}, 32'd0);
        check("post_rst_wd", {27'b0, mem_wd}, 32'd9);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_req2", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        run_access('{MEM_OP_LB, 32'h700, 32'h0, 32'h00000042, 5'd13, 1'b1, 32'h0, 32'h00000042, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RV32I core; sits between the EX/MEM register and mem_wb.
- Non-memory instructions pass straight through to mem_wb.
- Loads and stores are serialised into byte-wide requests on a req/ack memory port, with little-endian assembly and sign/zero extension.
- Holds the upstream pipeline via stall_req until the access completes.

Parameters:
- ADDR_W, 32, width of data addresses and of mem_addr.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high (`ENABLE)
- ex_wd  in  5  destination register from EX/MEM
- ex_wreg  in  1  register write enable from EX/MEM
- ex_wdata  in  32  ALU result from EX/MEM
- ex_mem_op  in  4  memory op code: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
- ex_mem_addr  in  ADDR_W  effective address
- ex_mem_sdata  in  32  store data (rs2)
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- stall_req  out  1  hold IF..EX/MEM; inputs are stable while high
- mem_req  out  1  byte request valid
- mem_we  out  1  1 = write byte
- mem_addr  out  ADDR_W  byte address
- mem_wbyte  out  8  write byte
- mem_rbyte  in  8  read byte, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse for the current request

Behaviour:
- Registered state:
  - FSM state: IDLE, ACCESS, DONE.
  - idx: 2-bit byte index.
  - buf: 32-bit assembly buffer.
  - All other outputs are combinational from state and inputs.
- Reset (rst == `ENABLE, sampled at posedge):
  - Registered state: state=IDLE, idx=0, buf=0.
  - While rst is high, outputs forced: mem_req=0, mem_we=0, stall_req=0, mem_wreg=`DISABLE, mem_wd=`NOP_REG_ADDR, mem_wdata=`ZERO_32.
  - Reset mid-access abandons the transfer; no further request is issued.
- Byte count n: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- IDLE:
  - op == NONE: outputs = ex_wd/ex_wreg/ex_wdata, stall_req=0, 0-cycle pass-through.
  - op != NONE: stall_req=1 combinationally in the same cycle; mem_wreg=`DISABLE and mem_wd=`NOP_REG_ADDR (bubble into mem_wb).
  - Next posedge: state -> ACCESS, idx=0.
- ACCESS:
  - Outputs: mem_req=1, mem_addr=ex_mem_addr+idx (wraps modulo 2^ADDR_W), mem_we=1 for stores, mem_wbyte=ex_mem_sdata[8*idx+7:8*idx].
  - mem_addr/mem_we/mem_wbyte stay stable until ack.
  - stall_req=1 and bubble outputs throughout.
  - On a mem_ack cycle: loads write buf[8*idx+7:8*idx] = mem_rbyte.
  - Ack on byte idx < n-1: idx += 1, mem_req stays high (back-to-back allowed).
  - Ack on byte idx == n-1: state -> DONE.
  - No ack: hold (unbounded wait).
- DONE (exactly one cycle):
  - Outputs: stall_req=0, mem_req=0, mem_wd=ex_wd, mem_wreg=ex_wreg.
  - mem_wdata for loads:
    - LB: sign-extend buf[7:0].
    - LBU: zero-extend buf[7:0].
    - LH: sign-extend buf[15:0].
    - LHU: zero-extend buf[15:0].
    - LW: buf.
  - mem_wdata for stores: ex_wdata.
  - Next posedge: state -> IDLE, buf=0. mem_wb captures the result at that same edge, and EX/MEM advances.
- Minimum latency: 1 + n + 1 cycles from op arrival to result, assuming single-cycle acks.
- Misaligned addresses are not trapped; bytes are accessed sequentially.
- mem_ack while mem_req=0 is ignored.
- Unknown op codes are treated as NONE.

Decomposition:
- Shared defines header, alongside `ENABLE/`DISABLE/`ZERO_32/`NOP_REG_ADDR:
  - MEM_OP_* codes and the `MEM_OP_BUS width.
  - Stage state encodings.
- No sub-module. The FSM, byte mux and extension logic live in mem_stage.

Test Plan:
- op=NONE, ex_wd=5, ex_wreg=1, ex_wdata=0x1234 -> same-cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234; stall_req=0, mem_req=0.
- LW at 0x100; memory returns bytes 0x78,0x56,0x34,0x12 with immediate acks -> addrs 0x100..0x103 in order; DONE mem_wdata=0x12345678; stall_req high for exactly 5 cycles.
- LB at 0x200 returning 0x80 -> mem_wdata=0xFFFFFF80; same access as LBU -> 0x00000080; LH returning 0x00,0x80 -> 0xFFFF8000.
- SH at 0xFFFFFFFF, sdata=0xAABBCCDD -> writes 0xDD at 0xFFFFFFFF then 0xCC at 0x00000000 (wrap); mem_we=1 on both; no register write.
- LW with ack delayed 3 cycles per byte -> mem_req, mem_addr and stall_req held stable between acks; stray mem_ack in IDLE has no effect.
- rst asserted during byte 2 of an LW -> next cycle state=IDLE, mem_req=0, stall_req=0, bubble outputs; a subsequent LB completes normally.
